// File: rtl/chacha_stream_xor.sv
// chacha_stream_xor: drives chacha_core and XORs each 512-bit keystream block word-by-word onto a 32-bit stream.
// Build macro CHACHA_PREFETCH_EN adds a spare block buffer so the next block is fetched while the current one streams.
module chacha_stream_xor #(
    parameter int WORDS_PER_BLK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] key,
    input  logic [63:0]  iv,
    input  logic [63:0]  ctr0,
    output logic         busy,
    output logic         done,
    output logic         err_wrap,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  in_data,
    input  logic         in_last,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_data,
    output logic         out_last,
    output logic         core_init,
    output logic         core_next,
    output logic [255:0] core_key,
    output logic [63:0]  core_iv,
    output logic [63:0]  core_ctr,
    input  logic         core_ready,
    input  logic [511:0] core_block,
    input  logic         core_block_valid,
    output logic [2:0]   dbg_state
);
    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_REQ      = 3'd1;
    localparam logic [2:0] S_WAIT_BLK = 3'd2;
    localparam logic [2:0] S_STREAM   = 3'd3;
    localparam logic [2:0] S_DRAIN    = 3'd4;
    localparam logic [3:0] LAST_IDX   = 4'(WORDS_PER_BLK - 1);

    logic [2:0]   state_q, state_d;
    logic [3:0]   idx_q, idx_d;
    logic [63:0]  blk_cnt_q, blk_cnt_d;
    logic [511:0] ks_q, ks_d;
    logic         first_q, first_d, cbv_q;
    logic         busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic         ov_q, ov_d, ol_q, ol_d;
    logic [31:0]  od_q, od_d, ks_word;
    logic         init_q, init_d, next_q, next_d;
    logic [255:0] key_q, key_d;
    logic [63:0]  iv_q, iv_d, ctr_q, ctr_d;
    logic         accept, blk_edge;
`ifdef CHACHA_PREFETCH_EN
    logic [511:0] spare_q, spare_d;
    logic         pf_pend_q, pf_pend_d, pf_have_q, pf_have_d;
`endif

    // Both streams use valid/ready: a word moves on a cycle where valid & ready are both high;
    // out_valid/out_data/out_last hold steady until out_ready, and in_ready never depends on in_valid.
    assign in_ready  = (state_q == S_STREAM) && (!ov_q || out_ready);
    assign accept    = in_valid && in_ready;
    assign blk_edge  = core_block_valid && !cbv_q;

    assign busy      = busy_q;
    assign done      = done_q;
    assign err_wrap  = err_q;
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = ol_q;
    assign core_init = init_q;
    assign core_next = next_q;
    assign core_key  = key_q;
    assign core_iv   = iv_q;
    assign core_ctr  = ctr_q;
    assign dbg_state = state_q;

    // Word 0 is the most significant word of the block.
    always_comb begin
        ks_word = '0;
        for (int w = 0; w < 16; w++) begin
            if (idx_q == 4'(w)) ks_word = ks_q[511 - 32*w -: 32];
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        blk_cnt_d = blk_cnt_q;
        ks_d      = ks_q;
        first_d   = first_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = err_q;
        ov_d      = ov_q;
        od_d      = od_q;
        ol_d      = ol_q;
        init_d    = 1'b0;
        next_d    = 1'b0;
        key_d     = key_q;
        iv_d      = iv_q;
        ctr_d     = ctr_q;
`ifdef CHACHA_PREFETCH_EN
        spare_d   = spare_q;
        pf_pend_d = pf_pend_q;
        pf_have_d = pf_have_q;
`endif
        if (ov_q && out_ready) ov_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d     = key;
                    iv_d      = iv;
                    ctr_d     = ctr0;
                    blk_cnt_d = ctr0;
                    busy_d    = 1'b1;
                    err_d     = 1'b0;
                    first_d   = 1'b1;
                    state_d   = S_REQ;
                end
            end
            S_REQ: begin
                if (core_ready) begin
                    init_d  = first_q;
                    next_d  = !first_q;
                    first_d = 1'b0;
                    state_d = S_WAIT_BLK;
                end
            end
            S_WAIT_BLK: begin
                if (blk_edge) begin
                    ks_d    = core_block;
                    idx_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
`ifdef CHACHA_PREFETCH_EN
                if (pf_pend_q && blk_edge) begin
                    spare_d   = core_block;
                    pf_have_d = 1'b1;
                    pf_pend_d = 1'b0;
                end
                if (idx_q == '0 && !pf_pend_q && !pf_have_q && core_ready && !(accept && in_last)) begin
                    next_d    = 1'b1;
                    pf_pend_d = 1'b1;
                end
`endif
                if (accept) begin
                    od_d = in_data ^ ks_word;
                    ol_d = in_last;
                    ov_d = 1'b1;
                    if (in_last) begin
                        state_d = S_DRAIN;
`ifdef CHACHA_PREFETCH_EN
                        pf_have_d = 1'b0;
                        pf_pend_d = 1'b0;
`endif
                    end else if (idx_q == LAST_IDX) begin
                        if (blk_cnt_q == '1) begin
                            err_d   = 1'b1;
                            state_d = S_DRAIN;
`ifdef CHACHA_PREFETCH_EN
                            pf_have_d = 1'b0;
                            pf_pend_d = 1'b0;
`endif
                        end else begin
                            blk_cnt_d = blk_cnt_q + 64'd1;
                            idx_d     = '0;
`ifdef CHACHA_PREFETCH_EN
                            // A block landing this very cycle is taken straight from the core bus.
                            pf_have_d = 1'b0;
                            pf_pend_d = 1'b0;
                            if (pf_have_q) ks_d = spare_q;
                            else if (pf_pend_q && blk_edge) ks_d = core_block;
                            else if (pf_pend_q) state_d = S_WAIT_BLK;
                            else state_d = S_REQ;
`else
                            state_d = S_REQ;
`endif
                        end
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!ov_q || out_ready) begin
                    ov_d    = 1'b0;
                    done_d  = !err_q;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            blk_cnt_q <= '0;
            ks_q      <= '0;
            first_q   <= 1'b0;
            cbv_q     <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            ov_q      <= 1'b0;
            od_q      <= '0;
            ol_q      <= 1'b0;
            init_q    <= 1'b0;
            next_q    <= 1'b0;
            key_q     <= '0;
            iv_q      <= '0;
            ctr_q     <= '0;
`ifdef CHACHA_PREFETCH_EN
            spare_q   <= '0;
            pf_pend_q <= 1'b0;
            pf_have_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            blk_cnt_q <= blk_cnt_d;
            ks_q      <= ks_d;
            first_q   <= first_d;
            cbv_q     <= core_block_valid;
            busy_q    <= busy_d;
            done_q    <= done_d;
            err_q     <= err_d;
            ov_q      <= ov_d;
            od_q      <= od_d;
            ol_q      <= ol_d;
            init_q    <= init_d;
            next_q    <= next_d;
            key_q     <= key_d;
            iv_q      <= iv_d;
            ctr_q     <= ctr_d;
`ifdef CHACHA_PREFETCH_EN
            spare_q   <= spare_d;
            pf_pend_q <= pf_pend_d;
            pf_have_q <= pf_have_d;
`endif
        end
    end
endmodule
